// File: rtl/regfile_port_arbiter.sv
// Shares register-file port B between the core datapath and a debug requester.
// Define REGFILE_ARB_DBG_BYTE_EN to add the DBG_BYTE_EN input for debug writes.
module regfile_port_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CORE_REGB_EN,
  input  logic        CORE_REGB_WEN,
  input  logic [1:0]  CORE_REGB_BYTE_EN,
  input  logic [3:0]  CORE_REGB_ADDR,
  input  logic [15:0] CORE_REGB_DIN,
  output logic        CORE_STALL,
  input  logic        DBG_REQ,
  input  logic        DBG_WR,
  input  logic [3:0]  DBG_ADDR,
  input  logic [15:0] DBG_WDATA,
`ifdef REGFILE_ARB_DBG_BYTE_EN
  input  logic [1:0]  DBG_BYTE_EN,
`endif
  output logic        DBG_ACK,
  output logic [15:0] DBG_RDATA,
  output logic        RF_EN,
  output logic        RF_WEN,
  output logic [1:0]  RF_BYTE_EN,
  output logic [3:0]  RF_ADDR,
  output logic [15:0] RF_DIN,
  input  logic [15:0] RF_DOUT
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;

  typedef enum logic [2:0] {IDLE, ARB, ISSUE, RDWAIT, DONE} state_t;

  typedef struct packed {
    logic              wr;
    logic [BE_W-1:0]   byte_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dbg_req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dbg_req_t          held_q, held_d;
  logic [BE_W-1:0]   dbg_be;

`ifdef REGFILE_ARB_DBG_BYTE_EN
  assign dbg_be = DBG_BYTE_EN;
`else
  assign dbg_be = BE_W'(2'b11);
`endif

  // State, counter, held request and registered debug outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      held_q    <= '0;
      DBG_ACK   <= 1'b0;
      DBG_RDATA <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      DBG_ACK <= (state_d == DONE);
      if (state_q == RDWAIT) begin
        DBG_RDATA <= RF_DOUT;
      end
    end
  end

  // Next state plus port-B steering; the core owns port B except in ISSUE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    CORE_STALL = 1'b0;
    RF_EN      = CORE_REGB_EN;
    RF_WEN     = CORE_REGB_WEN;
    RF_BYTE_EN = CORE_REGB_BYTE_EN;
    RF_ADDR    = CORE_REGB_ADDR;
    RF_DIN     = CORE_REGB_DIN;

    case (state_q)
      IDLE: begin
        if (DBG_REQ) begin
          held_d.wr      = DBG_WR;
          held_d.byte_en = dbg_be;
          held_d.addr    = DBG_ADDR;
          held_d.wdata   = DBG_WDATA;
          cnt_d          = '0;
          state_d        = ARB;
        end
      end
      ARB: begin
        if (!CORE_REGB_EN) begin
          state_d = ISSUE;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ISSUE: begin
        CORE_STALL = 1'b1;
        RF_EN      = 1'b1;
        RF_WEN     = held_q.wr;
        RF_BYTE_EN = held_q.byte_en;
        RF_ADDR    = held_q.addr;
        RF_DIN     = held_q.wdata;
        state_d    = held_q.wr ? DONE : RDWAIT;
      end
      RDWAIT: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
